// File: rtl/kei_i2c_pkg.sv
// rtl/kei_i2c_pkg.sv - shared types and constants for the I2C bus decoder
package kei_i2c_pkg;

  // Decoder FSM states: idle bus, inside a frame, one-cycle recovery after a broken STOP
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    HOLD = 2'd2
  } i2c_state_e;

  // Eight data bits plus the acknowledge bit
  localparam int unsigned I2C_SLOT_BITS = 9;

  typedef logic [7:0] i2c_byte_t;

endpackage

// File: rtl/kei_i2c_line_filter.sv
// rtl/kei_i2c_line_filter.sv - synchroniser, deglitch filter and edge flags for one bus line
module kei_i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   filt_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; resets to the released (high) bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Deglitch: the filtered level only follows after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_out == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_out;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Previous filtered level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= filt_q;
    end
  end

  assign filt = filt_q;
  assign rise = filt_q & ~prev_q;
  assign fall = ~filt_q & prev_q;

endmodule

// File: rtl/kei_i2c_bus_decoder.sv
// rtl/kei_i2c_bus_decoder.sv - passive I2C bus observer: conditions, bytes and ACKs
module kei_i2c_bus_decoder
  import kei_i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL_I,
  input  logic       SDA_I,
  output logic       bus_busy,
  output logic       start_pulse,
  output logic       rstart_pulse,
  output logic       stop_pulse,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_ack,
  output logic       byte_is_addr,
  output logic       rw,
  output logic       frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(I2C_SLOT_BITS - 1);
  localparam int         SETTLE   = SYNC_STAGES + FILT_LEN + 1;

  logic scl_raw, sda_raw;
  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic scl_steady_high, start_cond, stop_cond, partial;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] cnt_before_q, cnt_before_d;
  logic       rise_seen_q, rise_seen_d;
  i2c_byte_t  shreg_q, shreg_d, byte_data_d;
  logic       addr_flag_q, addr_flag_d;
  logic [4:0] settle_q;
  logic       settle_done, armed_q;
  logic       bus_busy_d, start_pulse_d, rstart_pulse_d, stop_pulse_d;
  logic       byte_valid_d, byte_ack_d, byte_is_addr_d, rw_d, frame_err_d;

  // Floating or unknown bus levels read as the pulled-up high
  assign scl_raw = (SCL_I !== 1'b0);
  assign sda_raw = (SDA_I !== 1'b0);

  kei_i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filter (
    .clk   (CLK),
    .rst_n (RST),
    .raw   (scl_raw),
    .filt  (scl_f),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  kei_i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filter (
    .clk   (CLK),
    .rst_n (RST),
    .raw   (sda_raw),
    .filt  (sda_f),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // A condition needs SCL high now and last cycle; a simultaneous SCL edge wins
  assign scl_steady_high = scl_f & ~scl_rise & ~scl_fall;
  assign start_cond      = armed_q & sda_fall & scl_steady_high;
  assign stop_cond       = sda_rise & scl_steady_high;

  // START/STOP always arrive during an SCL high phase whose rising edge already bumped
  // bit_cnt; judge the frame by the bits completed before that phase began
  assign partial = rise_seen_q ? (cnt_before_q != 4'd0) : (bit_cnt_q != 4'd0);

  // Arm START detection only once the filters carry real bus levels and the bus looks idle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (!settle_done) settle_q <= settle_q + 5'd1;
      if (settle_done && scl_f && sda_f) armed_q <= 1'b1;
    end
  end

  assign settle_done = (settle_q == 5'(SETTLE));

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_cond) state_d = BIT;
      BIT:     if (!start_cond && stop_cond) state_d = partial ? HOLD : IDLE;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output and datapath next values
  always_comb begin
    bus_busy_d     = bus_busy;
    start_pulse_d  = 1'b0;
    rstart_pulse_d = 1'b0;
    stop_pulse_d   = 1'b0;
    byte_valid_d   = 1'b0;
    frame_err_d    = 1'b0;
    byte_data_d    = byte_data;
    byte_ack_d     = byte_ack;
    byte_is_addr_d = byte_is_addr;
    rw_d           = rw;
    bit_cnt_d      = bit_cnt_q;
    cnt_before_d   = cnt_before_q;
    rise_seen_d    = rise_seen_q;
    shreg_d        = shreg_q;
    addr_flag_d    = addr_flag_q;
    case (state_q)
      IDLE: begin
        if (start_cond) begin
          start_pulse_d = 1'b1;
          bus_busy_d    = 1'b1;
          bit_cnt_d     = 4'd0;
          addr_flag_d   = 1'b1;
          rise_seen_d   = 1'b0;
        end else if (stop_cond) begin
          stop_pulse_d = 1'b1;
        end
      end
      BIT: begin
        if (start_cond) begin
          rstart_pulse_d = 1'b1;
          frame_err_d    = partial;
          bit_cnt_d      = 4'd0;
          addr_flag_d    = 1'b1;
          rise_seen_d    = 1'b0;
        end else if (stop_cond) begin
          stop_pulse_d = 1'b1;
          frame_err_d  = partial;
          bus_busy_d   = 1'b0;
          bit_cnt_d    = 4'd0;
          addr_flag_d  = 1'b0;
          rise_seen_d  = 1'b0;
        end else if (scl_rise) begin
          rise_seen_d  = 1'b1;
          cnt_before_d = bit_cnt_q;
          if (bit_cnt_q == LAST_BIT) begin
            byte_valid_d   = 1'b1;
            byte_data_d    = shreg_q;
            byte_ack_d     = sda_f;
            byte_is_addr_d = addr_flag_q;
            if (addr_flag_q) rw_d = shreg_q[0];
            addr_flag_d    = 1'b0;
            bit_cnt_d      = 4'd0;
          end else begin
            shreg_d   = {shreg_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (scl_fall) begin
          rise_seen_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus_busy     <= 1'b0;
      start_pulse  <= 1'b0;
      rstart_pulse <= 1'b0;
      stop_pulse   <= 1'b0;
      byte_valid   <= 1'b0;
      frame_err    <= 1'b0;
      byte_data    <= 8'h00;
      byte_ack     <= 1'b0;
      byte_is_addr <= 1'b0;
      rw           <= 1'b0;
      bit_cnt_q    <= 4'd0;
      cnt_before_q <= 4'd0;
      rise_seen_q  <= 1'b0;
      shreg_q      <= 8'h00;
      addr_flag_q  <= 1'b0;
    end else begin
      bus_busy     <= bus_busy_d;
      start_pulse  <= start_pulse_d;
      rstart_pulse <= rstart_pulse_d;
      stop_pulse   <= stop_pulse_d;
      byte_valid   <= byte_valid_d;
      frame_err    <= frame_err_d;
      byte_data    <= byte_data_d;
      byte_ack     <= byte_ack_d;
      byte_is_addr <= byte_is_addr_d;
      rw           <= rw_d;
      bit_cnt_q    <= bit_cnt_d;
      cnt_before_q <= cnt_before_d;
      rise_seen_q  <= rise_seen_d;
      shreg_q      <= shreg_d;
      addr_flag_q  <= addr_flag_d;
    end
  end

endmodule

// File: tb/tb_kei_i2c_bus_decoder.sv
// tb/tb_kei_i2c_bus_decoder.sv - self-checking bench for the I2C bus decoder
module tb_kei_i2c_bus_decoder;

  localparam int Q = 5;

  typedef enum int {EV_START, EV_RSTART, EV_STOP, EV_BYTE} ev_e;
  typedef enum int {OP_START, OP_RSTART, OP_BYTE, OP_STOP} op_e;

  typedef struct {
    ev_e        kind;
    logic [7:0] data;
    logic       ack;
    logic       addr;
    logic       rw;
    logic       ferr;
  } ev_t;

  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       ack;
    ev_e        kind;
    logic       addr;
    logic       rw;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       scl_low = 1'b0;
  logic       sda_low = 1'b0;
  wire        scl_bus;
  wire        sda_bus;
  logic       bus_busy, start_pulse, rstart_pulse, stop_pulse, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ack, byte_is_addr, rw, frame_err;

  int  checks = 0;
  int  failures = 0;
  int  busy_err = 0;
  logic in_frame = 1'b0;
  ev_t ev_q[$];
  vec_t vecs[14];

  assign scl_bus = scl_low ? 1'b0 : 1'bz;
  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (scl_bus);
  pullup (sda_bus);

  kei_i2c_bus_decoder #(.SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SCL_I        (scl_bus),
    .SDA_I        (sda_bus),
    .bus_busy     (bus_busy),
    .start_pulse  (start_pulse),
    .rstart_pulse (rstart_pulse),
    .stop_pulse   (stop_pulse),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ack     (byte_ack),
    .byte_is_addr (byte_is_addr),
    .rw           (rw),
    .frame_err    (frame_err)
  );

  always #5 CLK = ~CLK;

  function automatic ev_t mk_ev(input ev_e k);
    ev_t e;
    e.kind = k;
    e.data = byte_data;
    e.ack  = byte_ack;
    e.addr = byte_is_addr;
    e.rw   = rw;
    e.ferr = frame_err;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      in_frame = 1'b0;
    end else begin
      if (start_pulse)  ev_q.push_back(mk_ev(EV_START));
      if (rstart_pulse) ev_q.push_back(mk_ev(EV_RSTART));
      if (byte_valid)   ev_q.push_back(mk_ev(EV_BYTE));
      if (stop_pulse)   ev_q.push_back(mk_ev(EV_STOP));
      if (start_pulse)     in_frame = 1'b1;
      else if (stop_pulse) in_frame = 1'b0;
      if (bus_busy !== in_frame) busy_err++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_start();
    sda_low = 1'b1; wait_n(Q);
    scl_low = 1'b1; wait_n(Q);
  endtask

  task automatic do_rstart();
    sda_low = 1'b0; wait_n(Q);
    scl_low = 1'b0; wait_n(Q);
    sda_low = 1'b1; wait_n(Q);
    scl_low = 1'b1; wait_n(Q);
  endtask

  task automatic do_stop();
    sda_low = 1'b1; wait_n(Q);
    scl_low = 1'b0; wait_n(Q);
    sda_low = 1'b0; wait_n(3 * Q);
  endtask

  task automatic do_bit(input logic b);
    sda_low = ~b;   wait_n(Q);
    scl_low = 1'b0; wait_n(2 * Q);
    scl_low = 1'b1; wait_n(Q);
  endtask

  task automatic do_byte(input logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) do_bit(d[i]);
    do_bit(a);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {15'd0, bus_busy, start_pulse, rstart_pulse, stop_pulse, byte_valid, byte_data,
               byte_ack, byte_is_addr, rw, frame_err}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_START,  8'h00, 1'b0, EV_START,  1'b0, 1'b0};
    vecs[1]  = '{OP_BYTE,   8'hA1, 1'b0, EV_BYTE,   1'b1, 1'b1};
    vecs[2]  = '{OP_BYTE,   8'h5C, 1'b1, EV_BYTE,   1'b0, 1'b1};
    vecs[3]  = '{OP_STOP,   8'h00, 1'b0, EV_STOP,   1'b0, 1'b0};
    vecs[4]  = '{OP_START,  8'h00, 1'b0, EV_START,  1'b0, 1'b0};
    vecs[5]  = '{OP_BYTE,   8'h50, 1'b0, EV_BYTE,   1'b1, 1'b0};
    vecs[6]  = '{OP_RSTART, 8'h00, 1'b0, EV_RSTART, 1'b0, 1'b0};
    vecs[7]  = '{OP_BYTE,   8'h51, 1'b0, EV_BYTE,   1'b1, 1'b1};
    vecs[8]  = '{OP_STOP,   8'h00, 1'b0, EV_STOP,   1'b0, 1'b0};
    vecs[9]  = '{OP_START,  8'h00, 1'b0, EV_START,  1'b0, 1'b0};
    vecs[10] = '{OP_BYTE,   8'h00, 1'b1, EV_BYTE,   1'b1, 1'b0};
    vecs[11] = '{OP_BYTE,   8'hFF, 1'b0, EV_BYTE,   1'b0, 1'b0};
    vecs[12] = '{OP_STOP,   8'h00, 1'b0, EV_STOP,   1'b0, 1'b0};
    vecs[13] = '{OP_START,  8'h00, 1'b0, EV_START,  1'b0, 1'b0};

    wait_n(3);
    chk_outputs_zero("reset_outputs");
    RST = 1'b1;
    wait_n(20);

    for (int i = 0; i < 14; i++) begin
      ev_q.delete();
      case (vecs[i].op)
        OP_START:  do_start();
        OP_RSTART: do_rstart();
        OP_BYTE:   do_byte(vecs[i].data, vecs[i].ack);
        default:   do_stop();
      endcase
      chk($sformatf("v%0d_count", i), ev_q.size(), 1);
      if (ev_q.size() >= 1) begin
        chk($sformatf("v%0d_kind", i), ev_q[0].kind, vecs[i].kind);
        chk($sformatf("v%0d_frame_err", i), ev_q[0].ferr, 1'b0);
        if (vecs[i].kind == EV_BYTE) begin
          chk($sformatf("v%0d_data", i), ev_q[0].data, vecs[i].data);
          chk($sformatf("v%0d_ack", i), ev_q[0].ack, vecs[i].ack);
          chk($sformatf("v%0d_is_addr", i), ev_q[0].addr, vecs[i].addr);
          chk($sformatf("v%0d_rw", i), ev_q[0].rw, vecs[i].rw);
        end
      end
    end

    // close the frame opened by the last table entry
    ev_q.delete();
    do_stop();
    chk("close_stop_count", ev_q.size(), 1);
    chk("busy_after_table", bus_busy, 1'b0);

    // short SDA glitch while idle, then a glitch just long enough to pass
    ev_q.delete();
    wait_n(10);
    sda_low = 1'b1; wait_n(2);
    sda_low = 1'b0; wait_n(20);
    chk("glitch2_events", ev_q.size(), 0);
    chk("glitch2_busy", bus_busy, 1'b0);
    sda_low = 1'b1; wait_n(3);
    sda_low = 1'b0; wait_n(20);
    chk("glitch3_events", ev_q.size(), 2);
    if (ev_q.size() >= 2) begin
      chk("glitch3_first", ev_q[0].kind, EV_START);
      chk("glitch3_second", ev_q[1].kind, EV_STOP);
    end

    // STOP after four data bits
    ev_q.delete();
    wait_n(10);
    do_start();
    do_bit(1'b1); do_bit(1'b0); do_bit(1'b1); do_bit(1'b1);
    do_stop();
    chk("short_events", ev_q.size(), 2);
    if (ev_q.size() >= 2) begin
      chk("short_stop_kind", ev_q[1].kind, EV_STOP);
      chk("short_frame_err", ev_q[1].ferr, 1'b1);
    end
    chk("short_busy", bus_busy, 1'b0);

    // released (high-impedance) lines while idle
    ev_q.delete();
    scl_low = 1'b0;
    sda_low = 1'b0;
    wait_n(30);
    chk("float_events", ev_q.size(), 0);
    chk("float_busy", bus_busy, 1'b0);

    // reset in the middle of a byte, then a clean 0x3C transfer
    do_start();
    do_bit(1'b1); do_bit(1'b0); do_bit(1'b0); do_bit(1'b1); do_bit(1'b0);
    sda_low = 1'b0; wait_n(Q);
    scl_low = 1'b0; wait_n(Q);
    #1 RST = 1'b0;
    #1 chk_outputs_zero("midreset_now");
    ev_q.delete();
    wait_n(3);
    chk_outputs_zero("midreset_held");
    wait_n(5);
    RST = 1'b1;
    wait_n(20);
    chk("post_reset_events", ev_q.size(), 0);
    do_start();
    do_byte(8'h3C, 1'b0);
    do_stop();
    chk("post_reset_count", ev_q.size(), 3);
    if (ev_q.size() >= 3) begin
      chk("post_reset_k0", ev_q[0].kind, EV_START);
      chk("post_reset_k1", ev_q[1].kind, EV_BYTE);
      chk("post_reset_data", ev_q[1].data, 8'h3C);
      chk("post_reset_is_addr", ev_q[1].addr, 1'b1);
      chk("post_reset_rw", ev_q[1].rw, 1'b0);
      chk("post_reset_ack", ev_q[1].ack, 1'b0);
      chk("post_reset_k2", ev_q[2].kind, EV_STOP);
      chk("post_reset_ferr", ev_q[2].ferr | ev_q[1].ferr | ev_q[0].ferr, 1'b0);
    end

    chk("busy_tracking", busy_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kei_i2c_bus_decoder.md
Name: kei_i2c_bus_decoder

Overview:
- Passive RTL observer of the wired-AND I2C bus (SCL, SDA as resolved on the shared interface).
- Synchronises and deglitches both lines, detects START / repeated START / STOP, and deserialises each 9-bit slot into a data byte plus ACK bit.
- Sits directly downstream of the bus interface; feeds the monitor-side scoreboard and slave-side RTL.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser (legal range 2..4).
- FILT_LEN, 3, consecutive identical synchronised samples required before a filtered line changes (legal range 1..15).

Ports:
- CLK  input  1  system clock; must run at least 8x the SCL rate.
- RST  input  1  asynchronous, active-low reset.
- SCL_I  input  1  resolved bus SCL; any non-0 value (1, Z, X) counts as 1.
- SDA_I  input  1  resolved bus SDA; same resolution rule.
- bus_busy  output  1  high from START to STOP.
- start_pulse  output  1  1-cycle pulse on a START issued from idle.
- rstart_pulse  output  1  1-cycle pulse on a START issued while busy.
- stop_pulse  output  1  1-cycle pulse on STOP.
- byte_valid  output  1  1-cycle pulse when a 9-bit slot completes.
- byte_data  output  8  MSB-first byte; valid with byte_valid, held until the next one.
- byte_ack  output  1  9th bit: 0 = ACK, 1 = NACK.
- byte_is_addr  output  1  byte is the first after START or rSTART.
- rw  output  1  byte_data[0] of the last address byte.
- frame_err  output  1  1-cycle pulse on START or STOP with bit_cnt not 0.

Behaviour:
- Reset:
  - All outputs are 0. byte_data is 0x00.
  - The filtered lines and the synchronisers reset to 1.
  - State is IDLE and bit_cnt is 0.
- Input stage:
  - Each line passes through SYNC_STAGES flops.
  - A per-line counter in the filter (width covering FILT_LEN) counts cycles where the synchronised value differs from the filtered value.
  - The filtered value flips when that count reaches FILT_LEN.
  - Any matching sample clears the count, so a glitch shorter than FILT_LEN cycles is rejected.
- Edge detect on the filtered lines (scl_f, sda_f) uses the previous-cycle values.
- Bus conditions:
  - START: sda_f falls while scl_f is high in both the previous and the current cycle.
  - STOP: sda_f rises under the same SCL condition.
  - If scl_f and sda_f change in the same cycle, no condition is generated; the SCL edge is processed normally.
- FSM states: IDLE, BIT, HOLD.
  - IDLE to BIT on START: start_pulse, bus_busy set to 1, bit_cnt cleared to 0, addr_flag set to 1.
  - In BIT, each scl_f rising edge samples sda_f.
    - bit_cnt 0..7 shift into the byte register, MSB first.
    - At bit_cnt 8 the sample goes to byte_ack. byte_valid pulses in the same cycle as the register update.
    - byte_data is then the shifted byte, and byte_is_addr equals addr_flag.
    - If addr_flag is 1, rw is loaded from bit 0.
    - After that slot, addr_flag is cleared and bit_cnt wraps to 0.
  - BIT to BIT on START: rstart_pulse. bit_cnt and addr_flag are set as for a fresh START.
  - BIT to IDLE on STOP: stop_pulse, bus_busy cleared to 0.
  - HOLD is entered from BIT when frame_err fires on STOP. It returns to IDLE on the next cycle; no outputs are held in HOLD.
- frame_err fires on START or STOP when bit_cnt is not 0. The partial byte is discarded and byte_valid is not asserted.
- STOP in IDLE: stop_pulse is still asserted and bus_busy stays 0.
- Pulses are registered. Latency from a bus line change to the pulse is SYNC_STAGES + FILT_LEN + 1 CLK cycles.
- Reset asserted mid-transfer returns everything to the reset state immediately, asynchronously, with no pulses.
- After reset release, no START is reported until SDA has been filtered high while SCL is high.

Decomposition:
- Package kei_i2c_pkg holds:
  - the typedef enum for FSM states {IDLE, BIT, HOLD};
  - the constant I2C_SLOT_BITS = 9;
  - the byte typedef logic [7:0].
- Sub-module kei_i2c_line_filter: synchroniser plus deglitch counter plus rise/fall flags. It is instantiated twice, once for SCL and once for SDA.

Test Plan:
1. START, address 0xA1, ACK, data 0x5C, NACK, STOP.
   - Pulse sequence: start_pulse; byte_valid with 0xA1, byte_is_addr=1, byte_ack=0, rw=1; byte_valid with 0x5C, byte_is_addr=0, byte_ack=1; stop_pulse.
   - bus_busy is high between start_pulse and stop_pulse.
2. START, 0x50 with ACK, then rSTART, 0x51 with ACK, then STOP.
   - rstart_pulse fires once.
   - The second byte has byte_is_addr=1 and rw=1. No frame_err.
3. SDA glitch of 2 CLK cycles (FILT_LEN=3) while SCL is high and idle: no start_pulse, no stop_pulse, bus_busy stays 0.
   - A 3-cycle low produces start_pulse.
4. STOP after 4 data bits: frame_err and stop_pulse in the same cycle, no byte_valid, bus_busy goes to 0.
5. SCL_I and SDA_I driven Z or X while idle: treated as 1, with no pulses.
6. RST asserted after bit 5 of a byte, then released and a full 0x3C transfer run.
   - All outputs are 0 during reset.
   - The next transfer decodes 0x3C correctly, bit_cnt starts from 0, and there is no frame_err.
